// File: rtl/pc_unit.sv
// Program counter and fetch sequencer: start/halt control, single-level
// call/return link, and a saturating retired-instruction counter.
//
// state | meaning
// IDLE  | waiting for start, no fetch
// RUN   | fetching at pc_o every cycle
// HALT  | halt retired, pc_o frozen, done_o high
module pc_unit #(
  parameter int unsigned PC_W     = 12,
  parameter int unsigned START_PC = 0,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic             stall_i,
  input  logic             branch_taken_i,
  input  logic             jump_en_i,
  input  logic             call_en_i,
  input  logic             ret_en_i,
  input  logic             halt_i,
  input  logic [PC_W-1:0]  target_i,
  output logic [PC_W-1:0]  pc_o,
  output logic             fetch_valid_o,
  output logic             done_o,
  output logic [CNT_W-1:0] instr_count_o
);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_e;

  localparam logic [PC_W-1:0] START_ADDR = PC_W'(START_PC);

  state_e           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [PC_W-1:0]  link_q, link_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PC_W-1:0]  pc_inc;
  logic [CNT_W-1:0] cnt_inc;

  assign pc_inc  = pc_q + PC_W'(1);
  // Counter sticks at all-ones rather than wrapping.
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      pc_q    <= START_ADDR;
      link_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      link_q  <= link_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    link_d  = link_q;
    cnt_d   = cnt_q;
    if (start_i) begin
      state_d = RUN;
      pc_d    = START_ADDR;
      cnt_d   = '0;
    end else if (state_q == RUN && !stall_i) begin
      cnt_d = cnt_inc;
      if (halt_i) begin
        state_d = HALT;
      end else if (ret_en_i) begin
        pc_d = link_q;
      end else if (call_en_i) begin
        link_d = pc_inc;
        pc_d   = target_i;
      end else if (jump_en_i || branch_taken_i) begin
        pc_d = target_i;
      end else begin
        pc_d = pc_inc;
      end
    end
  end

  assign pc_o          = pc_q;
  assign fetch_valid_o = (state_q == RUN);
  assign done_o        = (state_q == HALT);
  assign instr_count_o = cnt_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed vector bench for pc_unit plus a narrow-counter instance for saturation.
module tb_pc_unit;

  typedef struct {
    logic        rst, st, stl, br, jmp, cl, rt, hlt;
    logic [11:0] tgt;
    logic [11:0] pc;
    logic        fv, dn;
    logic [15:0] cnt;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset, start, stall, branch_taken, jump_en, call_en, ret_en, halt;
  logic [11:0] target;
  logic [11:0] pc;
  logic        fetch_valid, done;
  logic [15:0] instr_count;

  logic        reset4, start4;
  logic [11:0] pc4;
  logic        fv4, done4;
  logic [3:0]  cnt4;

  int errors = 0;
  int checks = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  pc_unit dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .stall_i(stall),
    .branch_taken_i(branch_taken), .jump_en_i(jump_en), .call_en_i(call_en),
    .ret_en_i(ret_en), .halt_i(halt), .target_i(target),
    .pc_o(pc), .fetch_valid_o(fetch_valid), .done_o(done),
    .instr_count_o(instr_count)
  );

  pc_unit #(.CNT_W(4)) dut4 (
    .clk_i(clk), .reset_i(reset4), .start_i(start4), .stall_i(1'b0),
    .branch_taken_i(1'b0), .jump_en_i(1'b0), .call_en_i(1'b0),
    .ret_en_i(1'b0), .halt_i(1'b0), .target_i(12'd0),
    .pc_o(pc4), .fetch_valid_o(fv4), .done_o(done4),
    .instr_count_o(cnt4)
  );

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // ctl letters: R reset, S start, s stall, b branch, j jump, c call, r ret, h halt
  function automatic void add(string ctl, int tgt, int epc, bit efv, bit edn, int ecnt);
    vec_t v;
    v = '{default: '0};
    for (int i = 0; i < ctl.len(); i++) begin
      case (ctl[i])
        "R": v.rst = 1'b1;
        "S": v.st  = 1'b1;
        "s": v.stl = 1'b1;
        "b": v.br  = 1'b1;
        "j": v.jmp = 1'b1;
        "c": v.cl  = 1'b1;
        "r": v.rt  = 1'b1;
        "h": v.hlt = 1'b1;
        default: ;
      endcase
    end
    v.tgt = 12'(tgt);
    v.pc  = 12'(epc);
    v.fv  = efv;
    v.dn  = edn;
    v.cnt = 16'(ecnt);
    vecs.push_back(v);
  endfunction

  task automatic clear_in();
    reset = 0; start = 0; stall = 0; branch_taken = 0; jump_en = 0;
    call_en = 0; ret_en = 0; halt = 0; target = 12'd0;
  endtask

  initial begin
    clear_in();
    reset4 = 1'b1; start4 = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset pc", int'(pc), 0);
    chk("reset fetch_valid", int'(fetch_valid), 0);
    chk("reset done", int'(done), 0);
    chk("reset instr_count", int'(instr_count), 0);

    add("S",    0,    0, 1, 0, 0);
    add("",     0,    1, 1, 0, 1);
    add("",     0,    2, 1, 0, 2);
    add("",     0,    3, 1, 0, 3);
    add("",     0,    4, 1, 0, 4);
    add("",     0,    5, 1, 0, 5);
    add("j",   10,   10, 1, 0, 6);
    add("b",  352,  352, 1, 0, 7);
    add("",     0,  353, 1, 0, 8);
    add("j",  205,  205, 1, 0, 9);
    add("j",   20,   20, 1, 0, 10);
    add("c",  625,  625, 1, 0, 11);
    add("",     0,  626, 1, 0, 12);
    add("",     0,  627, 1, 0, 13);
    add("",     0,  628, 1, 0, 14);
    add("r",    0,   21, 1, 0, 15);
    add("r",    0,   21, 1, 0, 16);
    add("j",    7,    7, 1, 0, 17);
    add("shj", 99,    7, 1, 0, 17);
    add("shj", 99,    7, 1, 0, 17);
    add("h",    0,    7, 0, 1, 18);
    add("jcr", 99,    7, 0, 1, 18);
    add("S",    0,    0, 1, 0, 0);
    add("",     0,    1, 1, 0, 1);
    add("Ssj", 99,    0, 1, 0, 0);
    add("r",    0,   21, 1, 0, 1);
    add("j", 4095, 4095, 1, 0, 2);
    add("",     0,    0, 1, 0, 3);
    add("",     0,    1, 1, 0, 4);
    add("j",   40,   40, 1, 0, 5);
    add("R",    0,    0, 0, 0, 0);
    add("j",   99,    0, 0, 0, 0);
    add("S",    0,    0, 1, 0, 0);
    add("",     0,    1, 1, 0, 1);
    add("",     0,    2, 1, 0, 2);
    add("r",    0,    0, 1, 0, 3);
    add("bh",  55,    0, 0, 1, 4);

    foreach (vecs[i]) begin
      @(negedge clk);
      reset = vecs[i].rst; start = vecs[i].st; stall = vecs[i].stl;
      branch_taken = vecs[i].br; jump_en = vecs[i].jmp; call_en = vecs[i].cl;
      ret_en = vecs[i].rt; halt = vecs[i].hlt; target = vecs[i].tgt;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d pc", i), int'(pc), int'(vecs[i].pc));
      chk($sformatf("vec%0d fetch_valid", i), int'(fetch_valid), int'(vecs[i].fv));
      chk($sformatf("vec%0d done", i), int'(done), int'(vecs[i].dn));
      chk($sformatf("vec%0d instr_count", i), int'(instr_count), int'(vecs[i].cnt));
    end
    @(negedge clk);
    clear_in();

    // 4-bit counter: must saturate at 15 over 20 unstalled cycles
    reset4 = 1'b0;
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    chk("sat start count", int'(cnt4), 0);
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (k == 14 || k == 15 || k == 16 || k == 20)
        chk($sformatf("sat count k=%0d", k), int'(cnt4), (k < 15) ? k : 15);
    end
    chk("sat pc", int'(pc4), 20);
    chk("sat fetch_valid", int'(fv4), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, got running expected finished");
    $fatal(1);
  end

endmodule
